// File: rtl/gcd_unit.sv
// ---------------------------------------------------------------------------
// gcd_unit -- iterative binary (Stein) greatest-common-divisor engine.
//
// One operand pair is accepted in IDLE. REDUCE then applies one rule per
// clock. DONE holds the result until the consumer takes it.
//
// Ports
//   clk        sole clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair a_in/b_in presented
//   in_ready   unit accepts an operand pair this cycle (state IDLE)
//   a_in,b_in  unsigned operands, WIDTH bits
//   out_valid  gcd_out holds a valid result (state DONE)
//   out_ready  consumer accepts the result this cycle
//   gcd_out    greatest common divisor of the accepted pair
//   busy       high while in state REDUCE
//   cycles     (only with GCD_UNIT_CYCLE_COUNT_EN) REDUCE cycles used by the
//              most recent operation, saturating at 16'hFFFF
//
// Optional feature macro: GCD_UNIT_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module gcd_unit #(
    parameter int WIDTH = 32,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             busy
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] gcd_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // Status flags are kept as flops that always change together with
    // state_reg, so they are glitch-free decodes of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            k_reg         <= '0;
            gcd_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a_in;
                        b_reg        <= b_in;
                        k_reg        <= '0;
                        state_reg    <= REDUCE;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                REDUCE: begin
                    if (a_reg == '0 || b_reg == '0) begin
                        // One operand exhausted: the other one, times the
                        // common power of two stripped earlier, is the GCD.
                        gcd_reg       <= (a_reg | b_reg) << k_reg;
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else if (!a_reg[0] && !b_reg[0]) begin
                        a_reg <= a_reg >> 1;
                        b_reg <= b_reg >> 1;
                        k_reg <= k_reg + 1'b1;
                    end else if (!a_reg[0]) begin
                        a_reg <= a_reg >> 1;
                    end else if (!b_reg[0]) begin
                        b_reg <= b_reg >> 1;
                    end else if (a_reg >= b_reg) begin
                        // Difference of two odd values is even, so the
                        // halving is folded into the same cycle.
                        a_reg <= (a_reg - b_reg) >> 1;
                    end else begin
                        b_reg <= (b_reg - a_reg) >> 1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign gcd_out   = gcd_reg;

`ifdef GCD_UNIT_CYCLE_COUNT_EN
    logic [15:0] cycles_reg;

    // Counts every REDUCE cycle including the terminating one; cleared when
    // a new pair is accepted and otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_reg <= '0;
        end else if (state_reg == IDLE && in_valid) begin
            cycles_reg <= '0;
        end else if (state_reg == REDUCE && cycles_reg != 16'hFFFF) begin
            cycles_reg <= cycles_reg + 16'd1;
        end
    end

    assign cycles = cycles_reg;
`endif

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 2..64.
REQ-002 Parameter KW, default $clog2(WIDTH)+1, width of the internal common-power-of-two shift counter k.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair a_in/b_in presented.
REQ-006 in_ready  output  1  unit accepts an operand pair this cycle.
REQ-007 a_in  input  WIDTH  first operand, unsigned.
REQ-008 b_in  input  WIDTH  second operand, unsigned.
REQ-009 out_valid  output  1  gcd_out holds a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 gcd_out  output  WIDTH  greatest common divisor of the accepted pair.
REQ-012 busy  output  1  high while in state REDUCE.

Function
REQ-013 The unit SHALL implement a three-state FSM: IDLE, REDUCE, DONE; in_ready=(state==IDLE), out_valid=(state==DONE), busy=(state==REDUCE).
REQ-014 IDLE: on a rising edge with in_valid&&in_ready, the unit SHALL latch a=a_in, b=b_in, clear k to 0, and enter REDUCE.
REQ-015 REDUCE SHALL apply exactly one rule per cycle, in this priority: a==0 or b==0 -> gcd_out=(a|b)<<k, enter DONE; both even -> a>>=1, b>>=1, k+=1; a even -> a>>=1; b even -> b>>=1; both odd with a>=b -> a=(a-b)>>1; both odd with a<b -> b=(b-a)>>1.
REQ-016 Subtraction and shift SHALL be WIDTH-bit unsigned; (a|b)<<k SHALL never exceed WIDTH bits for legal inputs, and no truncation logic is required.
REQ-017 gcd(0,0) SHALL return 0; gcd(x,0) and gcd(0,x) SHALL return x after exactly one REDUCE cycle.
REQ-018 REDUCE SHALL terminate within 2*WIDTH+1 cycles for any input pair.
REQ-019 DONE: gcd_out and out_valid SHALL hold stable until a rising edge with out_ready=1, after which the state SHALL be IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE; a_in/b_in changes after acceptance SHALL not affect the result.
REQ-021 Back-to-back operation: minimum spacing between accepts SHALL be REDUCE cycles + 2 (DONE handshake cycle, then IDLE cycle).

Reset
REQ-022 rst=1 at a rising edge SHALL force state IDLE, gcd_out=0, a=b=0, k=0, regardless of the current state, including mid-REDUCE and DONE.
REQ-023 An operation aborted by reset SHALL produce no out_valid pulse; the first cycle after rst deasserts SHALL show in_ready=1, out_valid=0, busy=0.
REQ-024 While rst=1, in_valid SHALL not cause acceptance.

Configuration
REQ-025 Macro GCD_UNIT_CYCLE_COUNT_EN defined: adds output port cycles (16 bits) counting the REDUCE cycles of the most recent operation, including the terminating cycle, cleared on accept, saturating at 16'hFFFF, held through DONE and IDLE, reset to 0.
REQ-026 Macro undefined: no cycles port and no counter logic; all other behaviour is identical.

Verification
REQ-027 Reset, then a_in=12, b_in=18 accepted -> busy for 5 cycles, out_valid rises at the 5th edge after accept, gcd_out=6, cycles=5 when enabled.
REQ-028 a_in=0, b_in=0, then a_in=7, b_in=0 -> each result is 0 and 7 respectively, out_valid after 1 REDUCE cycle.
REQ-029 WIDTH=32, a_in=32'hFFFFFFFF, b_in=32'hFFFFFFFE -> gcd_out=1 within 65 REDUCE cycles; out_ready held low 10 cycles -> gcd_out and out_valid stable throughout.
REQ-030 Assert rst during the third REDUCE cycle of 48/36 -> next cycle state IDLE, gcd_out=0, no out_valid; a following 48/36 returns 12.
REQ-031 in_valid held high with changing operands during REDUCE and DONE -> only the pair accepted in IDLE is computed; random 1000 pairs at WIDTH=8 and WIDTH=32 match a reference GCD model.
